// File: rtl/tmds_channel_encoder.sv
// tmds_channel_encoder: DVI TMDS 8b/10b channel encoder, 2-stage pipeline.
// Optional: define TMDS_DISPARITY_DBG_EN for disp_dbg port and cnt check.
module tmds_channel_encoder #(
   parameter logic [1:0] RST_CD = 2'b00
) (
   input  logic       pixclk,
   input  logic       rst,
   input  logic       VDE,
   input  logic [1:0] CD,
   input  logic [7:0] D,
   output logic [9:0] TMDS
`ifdef TMDS_DISPARITY_DBG_EN
   ,
   output logic signed [4:0] disp_dbg
`endif
);

   function automatic logic [9:0] ctl_code(input logic [1:0] cd);
      logic [9:0] c;
      case (cd)
         2'b00:   c = 10'b1101010100;
         2'b01:   c = 10'b0010101011;
         2'b10:   c = 10'b0101010100;
         default: c = 10'b1010101011;
      endcase
      return c;
   endfunction

   logic [3:0] d_ones;
   logic       use_xnor;
   logic [8:0] q_m_c;

   logic       s1_vde;
   logic [1:0] s1_cd;
   logic [8:0] s1_qm;

   logic [3:0]        n1;
   logic [3:0]        n0;
   logic signed [4:0] diff;
   logic signed [4:0] cnt;
   logic signed [4:0] cnt_nxt;
   logic [9:0]        tmds_nxt;
   logic              case_a;
   logic              case_b;
   logic              q8;
   logic [7:0]        q;

   // Transition minimisation: choose XOR or XNOR chain from D's ones count
   always_comb begin
      d_ones = 4'd0;
      for (int i = 0; i < 8; i++) begin
         d_ones = d_ones + {3'b000, D[i]};
      end
      use_xnor = (d_ones > 4'd4) || ((d_ones == 4'd4) && !D[0]);
      q_m_c    = 9'd0;
      q_m_c[0] = D[0];
      for (int i = 1; i < 8; i++) begin
         q_m_c[i] = use_xnor ? ~(q_m_c[i-1] ^ D[i])
                             :  (q_m_c[i-1] ^ D[i]);
      end
      q_m_c[8] = ~use_xnor;
   end

   // Stage 1 register: q_m plus the aligned VDE and control symbol
   always_ff @(posedge pixclk) begin
      if (rst) begin
         s1_vde <= 1'b0;
         s1_cd  <= RST_CD;
         s1_qm  <= 9'd0;
      end else begin
         s1_vde <= VDE;
         s1_cd  <= CD;
         s1_qm  <= q_m_c;
      end
   end

   // DC balance: pick inversion from running disparity and q_m balance
   always_comb begin
      q8 = s1_qm[8];
      q  = s1_qm[7:0];
      n1 = 4'd0;
      for (int i = 0; i < 8; i++) begin
         n1 = n1 + {3'b000, q[i]};
      end
      n0   = 4'd8 - n1;
      diff = $signed({1'b0, n1}) - $signed({1'b0, n0});
      case_a = (cnt == 5'sd0) || (n1 == n0);
      case_b = !case_a &&
               (((cnt > 5'sd0) && (n1 > n0)) ||
                ((cnt < 5'sd0) && (n0 > n1)));
      tmds_nxt = ctl_code(s1_cd);
      cnt_nxt  = 5'sd0;
      if (s1_vde) begin
         unique case (1'b1)
            case_a: begin
               tmds_nxt = {~q8, q8, q8 ? q : ~q};
               cnt_nxt  = q8 ? (cnt + diff) : (cnt - diff);
            end
            case_b: begin
               tmds_nxt = {1'b1, q8, ~q};
               cnt_nxt  = cnt + (q8 ? 5'sd2 : 5'sd0) - diff;
            end
            default: begin
               tmds_nxt = {1'b0, q8, q};
               cnt_nxt  = cnt - (q8 ? 5'sd0 : 5'sd2) + diff;
            end
         endcase
      end
   end

   // Stage 2 register: output character and running disparity
   always_ff @(posedge pixclk) begin
      if (rst) begin
         TMDS <= ctl_code(RST_CD);
         cnt  <= 5'sd0;
      end else begin
         TMDS <= tmds_nxt;
         cnt  <= cnt_nxt;
      end
   end

`ifdef TMDS_DISPARITY_DBG_EN
   assign disp_dbg = cnt;

   // Disparity must stay even and bounded to fit the 5-bit counter
   always @(posedge pixclk) begin
      if (!rst) begin
         assert (!cnt[0] && (cnt >= -5'sd10) && (cnt <= 5'sd10));
      end
   end
`endif

endmodule

// File: tb/tb_tmds_channel_encoder.sv
// tb_tmds_channel_encoder: directed vectors plus model-checked soak
// for the TMDS channel encoder.
module tb_tmds_channel_encoder;

   logic       pixclk;
   logic       rst;
   logic       VDE;
   logic [1:0] CD;
   logic [7:0] D;
   logic [9:0] TMDS;
`ifdef TMDS_DISPARITY_DBG_EN
   logic signed [4:0] disp_dbg;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [9:0] C00 = 10'b1101010100;
   localparam logic [9:0] C01 = 10'b0010101011;
   localparam logic [9:0] C10 = 10'b0101010100;
   localparam logic [9:0] C11 = 10'b1010101011;

   logic [9:0] ctl_tab [4] = '{C00, C01, C10, C11};

   tmds_channel_encoder #(.RST_CD(2'b00)) dut (
      .pixclk (pixclk),
      .rst    (rst),
      .VDE    (VDE),
      .CD     (CD),
      .D      (D),
      .TMDS   (TMDS)
`ifdef TMDS_DISPARITY_DBG_EN
      ,
      .disp_dbg (disp_dbg)
`endif
   );

   initial pixclk = 1'b0;
   always #5 pixclk = ~pixclk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge pixclk);
      #1;
   endtask

   string      prev_tag;
   logic [9:0] prev_exp;
   bit         have_prev = 0;

   // Drive one vector; its result is checked two edges later
   task automatic push(input string tag, input logic vde,
                       input logic [1:0] cd, input logic [7:0] d,
                       input logic [9:0] exp);
      VDE = vde;
      CD  = cd;
      D   = d;
      tick();
      if (have_prev) chk(prev_tag, TMDS, prev_exp);
      prev_tag  = tag;
      prev_exp  = exp;
      have_prev = 1;
   endtask

   task automatic flush();
      push("idle_a", 1'b0, 2'b00, 8'h00, C00);
      push("idle_b", 1'b0, 2'b00, 8'h00, C00);
   endtask

   int m_cnt;

   task automatic model_step(input logic vde, input logic [1:0] cd,
                             input logic [7:0] d,
                             output logic [9:0] code);
      int         ones;
      int         bal;
      bit         inv;
      logic [8:0] qm;
      ones  = $countones(d);
      inv   = (ones > 4) || (ones == 4 && d[0] == 1'b0);
      qm    = '0;
      qm[0] = d[0];
      for (int k = 1; k < 8; k++) qm[k] = qm[k-1] ^ d[k] ^ inv;
      qm[8] = !inv;
      bal   = 2 * $countones(qm[7:0]) - 8;
      if (!vde) begin
         code  = ctl_tab[cd];
         m_cnt = 0;
      end else begin
         if (m_cnt == 0 || bal == 0) begin
            if (qm[8]) code = {2'b01, qm[7:0]};
            else       code = {2'b10, ~qm[7:0]};
         end else if ((m_cnt > 0) == (bal > 0)) begin
            code = {1'b1, qm[8], ~qm[7:0]};
         end else begin
            code = {1'b0, qm[8], qm[7:0]};
         end
         m_cnt += 2 * $countones(code) - 10;
      end
   endtask

   initial begin
      logic       v;
      logic [1:0] c;
      logic [7:0] d;
      logic [9:0] code;
      logic [9:0] p_code;
      logic       p_vde;
      int         p_cnt;
      int         obs_sum;

      rst = 1'b1;
      VDE = 1'b0;
      CD  = 2'b11;
      D   = 8'h00;
      repeat (3) tick();
      chk("rst_hold", TMDS, C00);
      rst = 1'b0;
      tick();
      chk("rel_flush", TMDS, C00);
      tick();
      chk("rel_live", TMDS, C11);

      push("ctl00", 1'b0, 2'b00, 8'h00, C00);
      push("ctl01", 1'b0, 2'b01, 8'h00, C01);
      push("ctl10", 1'b0, 2'b10, 8'h00, C10);
      push("ctl11", 1'b0, 2'b11, 8'h00, C11);
      flush();

      push("z0", 1'b1, 2'b00, 8'h00, 10'b0100000000);
      push("z1", 1'b1, 2'b00, 8'h00, 10'b1111111111);
      push("z2", 1'b1, 2'b00, 8'h00, 10'b0100000000);
      push("z3", 1'b1, 2'b00, 8'h00, 10'b1111111111);
      push("z4", 1'b1, 2'b00, 8'h00, 10'b0100000000);
      flush();

      push("ff0", 1'b1, 2'b00, 8'hFF, 10'b1000000000);
      push("ff_ctl", 1'b0, 2'b10, 8'hFF, C10);
      push("ff_cnt0", 1'b1, 2'b00, 8'h00, 10'b0100000000);
      flush();

      push("x55a", 1'b1, 2'b00, 8'h55, 10'b0100110011);
      push("x55b", 1'b1, 2'b00, 8'h55, 10'b0100110011);
      push("n4d0", 1'b1, 2'b00, 8'h1E, 10'b1001011111);
      flush();

      push("f8a", 1'b1, 2'b00, 8'hF8, 10'b1011111101);
      push("f8c", 1'b1, 2'b00, 8'hF8, 10'b0000000010);
      push("f8b", 1'b1, 2'b00, 8'hF8, 10'b1011111101);
      push("f8c2", 1'b1, 2'b00, 8'hF8, 10'b0000000010);
      flush();

      push("pre", 1'b0, 2'b01, 8'h00, C01);
      push("pulse", 1'b1, 2'b00, 8'h00, 10'b0100000000);
      push("post", 1'b0, 2'b01, 8'h00, C01);
      flush();

      VDE = 1'b1;
      CD  = 2'b00;
      D   = 8'h00;
      tick();
      chk("mid_ctl", TMDS, C00);
      tick();
      chk("mid_data", TMDS, 10'b0100000000);
      rst = 1'b1;
      tick();
      chk("mid_rst", TMDS, C00);
      rst = 1'b0;
      tick();
      chk("mid_rel", TMDS, C00);
      tick();
      chk("mid_cnt0", TMDS, 10'b0100000000);

      rst = 1'b1;
      tick();
      rst     = 1'b0;
      m_cnt   = 0;
      obs_sum = 0;
      p_code  = '0;
      p_vde   = 1'b0;
      p_cnt   = 0;
      for (int i = 0; i < 10000; i++) begin
         v = ($urandom_range(0, 19) != 0);
         c = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       d = 8'h00;
            1:       d = 8'hFF;
            default: d = 8'($urandom_range(0, 255));
         endcase
         model_step(v, c, d, code);
         VDE = v;
         CD  = c;
         D   = d;
         tick();
         if (i > 0) begin
            chk("soak_tmds", TMDS, p_code);
            if (p_vde) begin
               obs_sum += 2 * $countones(TMDS) - 10;
               chk("soak_disp", obs_sum, p_cnt);
               chk("soak_rng",
                   32'((obs_sum % 2 == 0) &&
                       (obs_sum >= -10) && (obs_sum <= 10)),
                   32'd1);
            end else begin
               obs_sum = 0;
            end
         end
         p_code = code;
         p_vde  = v;
         p_cnt  = m_cnt;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
